axil_master_arbiter: RTL



---
 rtl/axil_master_arbiter.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_master_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite slave port between NUM_MASTERS masters,
// one transaction at a time, with a response timeout that answers SLVERR on a hung slave.
module axil_master_arbiter #(
    parameter int          NUM_MASTERS    = 4,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF,
    localparam int         IDX_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    // upstream masters
    input  logic [NUM_MASTERS*32-1:0] s_axi_awaddr,
    input  logic [NUM_MASTERS*3-1:0]  s_axi_awprot,
    input  logic [NUM_MASTERS-1:0]    s_axi_awvalid,
    output logic [NUM_MASTERS-1:0]    s_axi_awready,
    input  logic [NUM_MASTERS*32-1:0] s_axi_wdata,
    input  logic [NUM_MASTERS*4-1:0]  s_axi_wstrb,
    input  logic [NUM_MASTERS-1:0]    s_axi_wvalid,
    output logic [NUM_MASTERS-1:0]    s_axi_wready,
    output logic [NUM_MASTERS*2-1:0]  s_axi_bresp,
    output logic [NUM_MASTERS-1:0]    s_axi_bvalid,
    input  logic [NUM_MASTERS-1:0]    s_axi_bready,
    input  logic [NUM_MASTERS*32-1:0] s_axi_araddr,
    input  logic [NUM_MASTERS*3-1:0]  s_axi_arprot,
    input  logic [NUM_MASTERS-1:0]    s_axi_arvalid,
    output logic [NUM_MASTERS-1:0]    s_axi_arready,
    output logic [NUM_MASTERS*32-1:0] s_axi_rdata,
    output logic [NUM_MASTERS*2-1:0]  s_axi_rresp,
    output logic [NUM_MASTERS-1:0]    s_axi_rvalid,
    input  logic [NUM_MASTERS-1:0]    s_axi_rready,
    // downstream slave
    output logic [31:0]               m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [31:0]               m_axi_wdata,
    output logic [3:0]                m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [31:0]               m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [31:0]               m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    // status
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_idx,
    output logic [15:0]               timeout_count
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_RESP, S_RD, S_RD_RESP, S_ERR_B, S_ERR_R
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_aw_done;
    logic             r_w_done;
    logic             r_ar_done;
    logic             r_err_first;
    logic             r_busy;
    logic [15:0]      r_timeout_count;

    logic [NUM_MASTERS-1:0] w_req_w;
    logic [NUM_MASTERS-1:0] w_req_r;
    logic [NUM_MASTERS-1:0] w_req;
    logic [IDX_W-1:0]       w_winner;
    logic                   w_active;
    logic                   w_to;
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_b_hs;
    logic                   w_ar_hs;
    logic                   w_r_hs;
    logic                   w_s_awready;
    logic                   w_s_wready;
    logic                   w_s_bvalid;
    logic [1:0]             w_s_bresp;
    logic                   w_s_arready;
    logic                   w_s_rvalid;
    logic [1:0]             w_s_rresp;
    logic [31:0]            w_s_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_req
            assign w_req_w[gi] = s_axi_awvalid[gi] & s_axi_wvalid[gi];
            assign w_req_r[gi] = s_axi_arvalid[gi];
            assign w_req[gi]   = w_req_w[gi] | w_req_r[gi];
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest one after r_last wins.
    always_comb begin
        int unsigned idx;
        w_winner = r_last;
        idx      = 0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            idx = int'(r_last) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (w_req[idx]) w_winner = IDX_W'(idx);
        end
    end

    assign w_active = (r_state == S_WR) || (r_state == S_WR_RESP) ||
                      (r_state == S_RD) || (r_state == S_RD_RESP);
    assign w_to     = w_active && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Downstream payloads follow the granted master; only valids/readies are gated.
    assign m_axi_awaddr  = s_axi_awaddr[int'(r_grant)*32 +: 32];
    assign m_axi_awprot  = s_axi_awprot[int'(r_grant)*3 +: 3];
    assign m_axi_wdata   = s_axi_wdata[int'(r_grant)*32 +: 32];
    assign m_axi_wstrb   = s_axi_wstrb[int'(r_grant)*4 +: 4];
    assign m_axi_araddr  = s_axi_araddr[int'(r_grant)*32 +: 32];
    assign m_axi_arprot  = s_axi_arprot[int'(r_grant)*3 +: 3];

    assign m_axi_awvalid = (r_state == S_WR) && s_axi_awvalid[r_grant] && !r_aw_done && !w_to;
    assign m_axi_wvalid  = (r_state == S_WR) && s_axi_wvalid[r_grant] && !r_w_done && !w_to;
    assign m_axi_arvalid = (r_state == S_RD) && s_axi_arvalid[r_grant] && !w_to;
    assign m_axi_bready  = (r_state == S_IDLE) ||
                           ((r_state == S_WR_RESP) && !w_to && s_axi_bready[r_grant]);
    assign m_axi_rready  = (r_state == S_IDLE) ||
                           ((r_state == S_RD_RESP) && !w_to && s_axi_rready[r_grant]);

    assign w_aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_w_hs  = m_axi_wvalid && m_axi_wready;
    assign w_ar_hs = m_axi_arvalid && m_axi_arready;
    assign w_b_hs  = (r_state == S_WR_RESP) && m_axi_bvalid && m_axi_bready;
    assign w_r_hs  = (r_state == S_RD_RESP) && m_axi_rvalid && m_axi_rready;

    // Upstream view of the granted master; the first error cycle swallows any pending request.
    assign w_s_awready = ((r_state == S_WR) && m_axi_awready && !r_aw_done && !w_to) ||
                         ((r_state == S_ERR_B) && r_err_first && !r_aw_done);
    assign w_s_wready  = ((r_state == S_WR) && m_axi_wready && !r_w_done && !w_to) ||
                         ((r_state == S_ERR_B) && r_err_first && !r_w_done);
    assign w_s_bvalid  = ((r_state == S_WR_RESP) && m_axi_bvalid && !w_to) || (r_state == S_ERR_B);
    assign w_s_bresp   = (r_state == S_ERR_B)   ? 2'b10 :
                         (r_state == S_WR_RESP) ? m_axi_bresp : 2'b00;
    assign w_s_arready = ((r_state == S_RD) && m_axi_arready && !w_to) ||
                         ((r_state == S_ERR_R) && r_err_first && !r_ar_done);
    assign w_s_rvalid  = ((r_state == S_RD_RESP) && m_axi_rvalid && !w_to) || (r_state == S_ERR_R);
    assign w_s_rresp   = (r_state == S_ERR_R)   ? 2'b10 :
                         (r_state == S_RD_RESP) ? m_axi_rresp : 2'b00;
    assign w_s_rdata   = (r_state == S_ERR_R)   ? ERR_RDATA :
                         (r_state == S_RD_RESP) ? m_axi_rdata : 32'h0;

    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_up
            logic w_sel;
            assign w_sel = (r_grant == IDX_W'(gi));
            assign s_axi_awready[gi]        = w_sel && w_s_awready;
            assign s_axi_wready[gi]         = w_sel && w_s_wready;
            assign s_axi_bvalid[gi]         = w_sel && w_s_bvalid;
            assign s_axi_bresp[gi*2 +: 2]   = w_sel ? w_s_bresp : 2'b00;
            assign s_axi_arready[gi]        = w_sel && w_s_arready;
            assign s_axi_rvalid[gi]         = w_sel && w_s_rvalid;
            assign s_axi_rresp[gi*2 +: 2]   = w_sel ? w_s_rresp : 2'b00;
            assign s_axi_rdata[gi*32 +: 32] = w_sel ? w_s_rdata : 32'h0;
        end
    endgenerate

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state         <= S_IDLE;
            r_grant         <= '0;
            r_last          <= IDX_W'(NUM_MASTERS - 1);
            r_cnt           <= '0;
            r_aw_done       <= 1'b0;
            r_w_done        <= 1'b0;
            r_ar_done       <= 1'b0;
            r_err_first     <= 1'b0;
            r_busy          <= 1'b0;
            r_timeout_count <= '0;
        end else if (w_to) begin
            r_state     <= ((r_state == S_WR) || (r_state == S_WR_RESP)) ? S_ERR_B : S_ERR_R;
            r_err_first <= 1'b1;
            if (r_timeout_count != 16'hFFFF) r_timeout_count <= r_timeout_count + 16'd1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_grant     <= w_winner;
                        r_last      <= w_winner;
                        r_cnt       <= '0;
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
                        r_ar_done   <= 1'b0;
                        r_err_first <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= w_req_w[w_winner] ? S_WR : S_RD;
                    end
                end
                S_WR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) r_state <= S_WR_RESP;
                end
                S_WR_RESP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_b_hs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_RD: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_ar_hs) begin
                        r_ar_done <= 1'b1;
                        r_state   <= S_RD_RESP;
                    end
                end
                S_RD_RESP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_r_hs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_ERR_B: begin
                    r_err_first <= 1'b0;
                    if (s_axi_bready[r_grant]) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_ERR_R: begin
                    r_err_first <= 1'b0;
                    if (s_axi_rready[r_grant]) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign grant_idx     = r_grant;
    assign timeout_count = r_timeout_count;

endmodule
